alu_cmd_sequencer: RTL and testbench
====================================

# alu_cmd_sequencer

Upstream issue stage for the 8-bit ALU. It accepts operand/opcode commands over a valid/ready handshake and buffers them in a small FIFO. It presents one command at a time on registered ALU inputs, samples the ALU's combinational result one cycle later, and holds that result under a valid/ready handshake until the consumer takes it. Commands complete strictly in order, and there is at most one command in flight in the ALU.

## Interface
Parameters:
- DEPTH, 4, command FIFO depth; power of 2, ≥ 2
- W, 8, operand and result width; matches the ALU

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  command present on in_a/in_b/in_op
- in_ready  out  1  FIFO can accept; equals (count != DEPTH)
- in_a  in  W  operand A
- in_b  in  W  operand B
- in_op  in  3  ALU opcode; all 8 codes are legal and passed through unmodified
- alu_a  out  W  registered operand A to ALU
- alu_b  out  W  registered operand B to ALU
- alu_op  out  3  registered opcode to ALU
- alu_out  in  W  combinational ALU result
- res_valid  out  1  res_data/res_op hold a completed result
- res_ready  in  1  consumer accepts result
- res_data  out  W  captured ALU result
- res_op  out  3  opcode that produced res_data
- count  out  log2(DEPTH)+1  FIFO occupancy, 0..DEPTH

## Operation
- Push: in_valid && in_ready at an edge writes {in_a, in_b, in_op} at the write pointer. If in_valid is high while full, nothing is written and the command is not lost upstream, because in_ready is low.
- Pointers wrap modulo DEPTH. The full/empty decision uses count, never pointer equality alone.
- FSM states:
  - IDLE → DRIVE when count != 0: pop the head into alu_a/alu_b/alu_op.
  - DRIVE → HOLD unconditionally: res_data <= alu_out, res_op <= alu_op, res_valid <= 1.
  - HOLD with res_valid && res_ready:
    - if count != 0: pop the next head into the alu_* registers and go to DRIVE;
    - else: go to IDLE.
  - In both cases res_valid <= 0.
  - HOLD without a handshake: stay; res_data/res_op stable.
- A pop happens only on IDLE→DRIVE or HOLD→DRIVE.
- Simultaneous push and pop in one cycle: count unchanged, both operations take effect. This is legal when full, but in_ready is still low when full, so no push occurs in that case.
- The alu_* registers hold their last value outside DRIVE and do not return to 0.
- The block performs no arithmetic. res_data is exactly the alu_out value present during the DRIVE cycle.

## Timing
- Reset values: in_ready = 1, count = 0, alu_a = alu_b = 0, alu_op = 0, res_valid = 0, res_data = 0, res_op = 0. FSM = IDLE, both pointers = 0.
- Reset mid-operation flushes the FIFO and drops any in-flight or held result. res_valid is low the cycle after the reset edge.
- Latency, empty and idle: a command accepted at edge E0 is popped at E1 and produces res_valid = 1 after E2, so the result is visible in the cycle following E2.
- Throughput with res_ready held high: one result every 2 cycles.
- A stalled res_ready back-pressures into the FIFO. in_ready drops after DEPTH commands are queued beyond the held one.
- in_ready is derived from registered count only. There is no combinational path from res_ready to in_ready.
- alu_out is sampled only at the DRIVE→HOLD edge. The ALU gets a full cycle to settle.

## Test plan
Bench ALU stand-in: alu_out = alu_a + alu_b (mod 256).
- Reset, then push (a=0x12, b=0x34, op=3) at E0 with res_ready=1 → alu_a=0x12 after E1; res_valid=1, res_data=0x46, res_op=3 after E2; res_valid=0 after E3.
- res_ready=0, push 5 commands (a=i, b=0x10, op=i), i=0..4, DEPTH=4 → in_ready low once count=4. Set res_ready=1 → results 0x10,0x11,0x12,0x13,0x14 in order, with op 0..4; none lost or duplicated.
- Wrap: stream 10 commands (a=0xF0+i, b=0x20) with random in_valid/res_ready gaps → results 0x10+i in order; count returns to 0; pointers have wrapped.
- Simultaneous push and pop: count=2 in HOLD; handshake and push on the same edge → count stays 2; next result matches the next FIFO entry.
- Overflow wrap: a=0xFF, b=0x01, op=7 → res_data=0x00, res_op=7; alu_* unchanged afterwards while IDLE.
- Assert rst while in HOLD with count=3 → next cycle res_valid=0, count=0, in_ready=1, alu_*=0. A fresh command then completes with the nominal 2-cycle latency.

Source files
------------

// File: rtl/alu_cmd_sequencer_if.sv
// Command/result handshake bundle between the issue stage and its neighbours.
interface alu_cmd_sequencer_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [2:0]   in_op;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic [2:0]   res_op;

  // Producer of commands / consumer of results
  modport master (
    output in_valid, in_a, in_b, in_op, res_ready,
    input  in_ready, res_valid, res_data, res_op
  );

  // The sequencer itself
  modport slave (
    input  in_valid, in_a, in_b, in_op, res_ready,
    output in_ready, res_valid, res_data, res_op
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the 8-bit ALU: buffers commands in a FIFO, drives one at a
// time into registered ALU inputs, captures the result a cycle later and
// holds it until the consumer accepts it. Strictly in order, one in flight.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_cmd_sequencer_if.slave     bus,
  output logic [W-1:0]           alu_a,
  output logic [W-1:0]           alu_b,
  output logic [2:0]             alu_op,
  input  logic [W-1:0]           alu_out,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 2 * W + 3;

  typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;

  state_t          state;
  state_t          state_next;
  logic            push;
  logic            pop;
  logic            capture;
  logic            release_res;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [EW-1:0]   mem [DEPTH];
  logic [EW-1:0]   head;

  // Full decision from registered count only, so res_ready never reaches it
  assign bus.in_ready = (count != CW'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign head         = mem[rd_ptr];

  // Next-state and per-cycle control strobes
  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          state_next = DRIVE;
        end
      end
      DRIVE: begin
        capture    = 1'b1;
        state_next = HOLD;
      end
      HOLD: begin
        if (bus.res_valid && bus.res_ready) begin
          release_res = 1'b1;
          if (count != '0) begin
            pop        = 1'b1;
            state_next = DRIVE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 depth
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage, packed as {a, b, op}
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= {bus.in_a, bus.in_b, bus.in_op};
  end

  // ALU operand registers and result holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a         <= '0;
      alu_b         <= '0;
      alu_op        <= '0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_op    <= '0;
    end else begin
      if (pop) {alu_a, alu_b, alu_op} <= head;
      if (capture) begin
        bus.res_data  <= alu_out;
        bus.res_op    <= alu_op;
        bus.res_valid <= 1'b1;
      end else if (release_res) begin
        bus.res_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with an adder standing in for the ALU.
module tb_alu_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int W     = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_out;
  logic [2:0]   count;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [10:0] sb [$];

  alu_cmd_sequencer_if #(.W(W)) bus ();

  alu_cmd_sequencer #(.DEPTH(DEPTH), .W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_op  (alu_op),
    .alu_out (alu_out),
    .count   (count)
  );

  assign alu_out = alu_a + alu_b;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Result monitor: a handshake seen at negedge completes on the next edge
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.res_valid && bus.res_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 32'(bus.res_data), 32'hDEAD);
        end else begin
          logic [10:0] e;
          e = sb.pop_front();
          check("res_data", 32'(bus.res_data), 32'(e[7:0]));
          check("res_op", 32'(bus.res_op), 32'(e[10:8]));
        end
      end
    end
  end

  task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    logic [7:0] s;
    s = a + b;
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_op = op;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back({op, s});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
    end
    bus.in_valid = 1'b0;
    check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bus.res_ready = 1'b1;
    for (int t = 0; t < 300 && sb.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_res_valid();
    for (int t = 0; t < 50; t++) begin
      if (bus.res_valid) return;
      @(posedge clk);
      #1;
    end
    check("res_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_latency(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    logic [7:0] s;
    s = a + b;
    bus.res_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_op = op;
    sb.push_back({op, s});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("lat_alu_a", 32'(alu_a), 32'(a));
    check("lat_alu_b", 32'(alu_b), 32'(b));
    check("lat_valid_e1", 32'(bus.res_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_valid_e2", 32'(bus.res_valid), 32'd1);
    check("lat_data_e2", 32'(bus.res_data), 32'(s));
    check("lat_op_e2", 32'(bus.res_op), 32'(op));
    @(posedge clk);
    #1;
    check("lat_valid_e3", 32'(bus.res_valid), 32'd0);
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_count"}, 32'(count), 32'd0);
    check({pfx, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({pfx, "_alu_a"}, 32'(alu_a), 32'd0);
    check({pfx, "_alu_b"}, 32'(alu_b), 32'd0);
    check({pfx, "_alu_op"}, 32'(alu_op), 32'd0);
    check({pfx, "_res_valid"}, 32'(bus.res_valid), 32'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_op = '0;
    bus.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("rst");
    check("rst_res_data", 32'(bus.res_data), 32'd0);
    check("rst_res_op", 32'(bus.res_op), 32'd0);

    // Nominal latency
    run_latency(8'h12, 8'h34, 3'd3);
    drain();

    // Back-pressure: one held + DEPTH queued
    bus.res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_cmd(8'(i), 8'h10, 3'(i));
    check("bp_count_full", 32'(count), 32'd4);
    check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    // Offer a command while full: must not be written
    bus.in_valid = 1'b1;
    bus.in_a = 8'hAA;
    bus.in_b = 8'hAA;
    bus.in_op = 3'd5;
    repeat (3) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("bp_count_hold", 32'(count), 32'd4);
    drain();
    check("bp_count_empty", 32'(count), 32'd0);

    // Wrap with random gaps on both sides
    begin
      bit done;
      done = 1'b0;
      fork
        begin
          for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 2)) begin
              @(posedge clk);
              #1;
            end
            push_cmd(8'hF0 + 8'(i), 8'h20, 3'(i));
          end
          done = 1'b1;
        end
        begin
          while (!done) begin
            @(posedge clk);
            #1;
            bus.res_ready = 1'($urandom_range(0, 1));
          end
        end
      join
    end
    drain();
    check("wrap_count_empty", 32'(count), 32'd0);

    // Simultaneous push and pop while holding a result
    bus.res_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_cmd(8'h40 + 8'(i), 8'h01, 3'(i + 1));
    wait_res_valid();
    check("sim_count_before", 32'(count), 32'd2);
    bus.res_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_a = 8'h55;
    bus.in_b = 8'h22;
    bus.in_op = 3'd6;
    sb.push_back({3'd6, 8'h77});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.res_ready = 1'b0;
    check("sim_count_after", 32'(count), 32'd2);
    drain();

    // Overflow wrap of the stand-in ALU; operand registers persist in IDLE
    run_latency(8'hFF, 8'h01, 3'd7);
    drain();
    check("ovf_alu_a_idle", 32'(alu_a), 32'hFF);
    check("ovf_alu_b_idle", 32'(alu_b), 32'h01);
    check("ovf_alu_op_idle", 32'(alu_op), 32'd7);

    // Reset while holding with 3 queued
    bus.res_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_cmd(8'h60 + 8'(i), 8'h02, 3'(i));
    wait_res_valid();
    check("mid_count_before", 32'(count), 32'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    check_reset_state("mid");
    run_latency(8'h21, 8'h05, 3'd2);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
